// File: rtl/barrel_cmd_seq.sv
// Command sequencer for the barrel rotate register: buffers rotate commands in a
// small FIFO, steps the barrel through load/rotate/capture and returns the final word.
module barrel_cmd_seq #(
  parameter int data_size  = 8,
  parameter int sel_width  = 3,
  parameter int cnt_width  = 4,
  parameter int fifo_depth = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [data_size-1:0] cmd_data,
  input  logic [sel_width-1:0] cmd_sel,
  input  logic [cnt_width-1:0] cmd_count,
  output logic                 Load,
  output logic [sel_width-1:0] Select,
  output logic [data_size-1:0] Data_in,
  input  logic [data_size-1:0] barrel_q,
  output logic                 result_valid,
  output logic [data_size-1:0] result_data,
  output logic                 busy
);

  localparam int ptr_w = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int ent_w = data_size + sel_width + cnt_width;
  localparam logic [ptr_w-1:0]     PTR_ONE  = ptr_w'(1);
  localparam logic [ptr_w:0]       OCC_ONE  = (ptr_w + 1)'(1);
  localparam logic [ptr_w:0]       OCC_FULL = (ptr_w + 1)'(fifo_depth);
  localparam logic [cnt_width-1:0] CNT_ONE  = cnt_width'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_ROTATE  = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  logic [ent_w-1:0]     fifo_mem_r [fifo_depth];
  logic [ptr_w-1:0]     wr_ptr_r, rd_ptr_r;
  logic [ptr_w:0]       occ_r;
  logic                 full_s, empty_s, push_s, pop_s;
  logic [ent_w-1:0]     head_s;
  logic [data_size-1:0] head_data_s;
  logic [sel_width-1:0] head_sel_s;
  logic [cnt_width-1:0] head_cnt_s;

  state_t               state_r, state_nxt_s;
  logic                 load_r, load_nxt_s;
  logic [sel_width-1:0] select_r, select_nxt_s;
  logic [data_size-1:0] data_in_r, data_in_nxt_s;
  logic [cnt_width-1:0] rem_r, rem_nxt_s;
  logic [sel_width-1:0] cur_sel_r, cur_sel_nxt_s;
  logic                 res_valid_r, res_valid_nxt_s;
  logic [data_size-1:0] res_data_r, res_data_nxt_s;

  assign full_s      = (occ_r == OCC_FULL);
  assign empty_s     = (occ_r == '0);
  assign push_s      = cmd_valid && !full_s;
  assign head_s      = fifo_mem_r[rd_ptr_r];
  assign head_data_s = head_s[ent_w-1 -: data_size];
  assign head_sel_s  = head_s[cnt_width +: sel_width];
  assign head_cnt_s  = head_s[cnt_width-1:0];

  assign cmd_ready    = !full_s;
  assign Load         = load_r;
  assign Select       = select_r;
  assign Data_in      = data_in_r;
  assign result_valid = res_valid_r;
  assign result_data  = res_data_r;
  assign busy         = (state_r != ST_IDLE);

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge Clock) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {cmd_data, cmd_sel, cmd_count};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OCC_ONE;
        2'b01:   occ_r <= occ_r - OCC_ONE;
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Next state and next values of every registered output
  always_comb begin
    state_nxt_s     = state_r;
    load_nxt_s      = 1'b0;
    select_nxt_s    = select_r;
    data_in_nxt_s   = data_in_r;
    rem_nxt_s       = rem_r;
    cur_sel_nxt_s   = cur_sel_r;
    res_valid_nxt_s = 1'b0;
    res_data_nxt_s  = res_data_r;
    pop_s           = 1'b0;
    case (state_r)
      ST_IDLE: begin
        select_nxt_s = '0;
        if (!empty_s) begin
          pop_s         = 1'b1;
          state_nxt_s   = ST_LOAD;
          load_nxt_s    = 1'b1;
          data_in_nxt_s = head_data_s;
          cur_sel_nxt_s = head_sel_s;
          rem_nxt_s     = head_cnt_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (rem_r != '0) begin
          state_nxt_s  = ST_ROTATE;
          select_nxt_s = cur_sel_r;
        end else begin
          state_nxt_s  = ST_CAPTURE;
          select_nxt_s = '0;
        end
      end
      ST_ROTATE: begin
        rem_nxt_s = rem_r - CNT_ONE;
        // rem_r == 1 marks the last rotate cycle, so the max count never wraps
        if (rem_r == CNT_ONE) begin
          state_nxt_s  = ST_CAPTURE;
          select_nxt_s = '0;
        end else begin
          state_nxt_s  = ST_ROTATE;
          select_nxt_s = cur_sel_r;
        end
      end
      ST_CAPTURE: begin
        select_nxt_s    = '0;
        res_data_nxt_s  = barrel_q;
        res_valid_nxt_s = 1'b1;
        state_nxt_s     = ST_IDLE;
      end
      default: begin
        select_nxt_s = '0;
        state_nxt_s  = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r     <= ST_IDLE;
      load_r      <= 1'b0;
      select_r    <= '0;
      data_in_r   <= '0;
      rem_r       <= '0;
      cur_sel_r   <= '0;
      res_valid_r <= 1'b0;
      res_data_r  <= '0;
    end else begin
      state_r     <= state_nxt_s;
      load_r      <= load_nxt_s;
      select_r    <= select_nxt_s;
      data_in_r   <= data_in_nxt_s;
      rem_r       <= rem_nxt_s;
      cur_sel_r   <= cur_sel_nxt_s;
      res_valid_r <= res_valid_nxt_s;
      res_data_r  <= res_data_nxt_s;
    end
  end

endmodule

// File: tb/tb_barrel_cmd_seq.sv
// Directed bench for barrel_cmd_seq, paired with a behavioural barrel
// (load on Load, otherwise rotate left by Select every cycle).
module tb_barrel_cmd_seq;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_data = 8'h00;
  logic [2:0] cmd_sel = 3'd0;
  logic [3:0] cmd_count = 4'd0;
  logic       Load;
  logic [2:0] Select;
  logic [7:0] Data_in;
  logic [7:0] barrel_q;
  logic       result_valid;
  logic [7:0] result_data;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  int         n_load = 0;
  int         n_sel = 0;
  logic [7:0] last_load = 8'h00;
  logic [2:0] last_sel = 3'd0;
  logic [7:0] res_q[$];

  barrel_cmd_seq dut (
    .Clock(Clock), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_sel(cmd_sel), .cmd_count(cmd_count),
    .Load(Load), .Select(Select), .Data_in(Data_in), .barrel_q(barrel_q),
    .result_valid(result_valid), .result_data(result_data), .busy(busy)
  );

  always #5 Clock = ~Clock;

  function automatic logic [7:0] rol8(input logic [7:0] v, input logic [2:0] s);
    logic [15:0] w;
    w = {v, v} << s;
    return w[15:8];
  endfunction

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) barrel_q <= 8'h00;
    else if (Load) barrel_q <= Data_in;
    else barrel_q <= rol8(barrel_q, Select);
  end

  always @(negedge Clock) begin
    if (Load) begin
      n_load++;
      last_load = Data_in;
    end
    if (Select != 3'd0) begin
      n_sel++;
      last_sel = Select;
    end
    if (result_valid) res_q.push_back(result_data);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge Clock);
    #1;
  endtask

  // One push edge, then count edges until result_valid (bounded at 40)
  task automatic push_and_wait(input logic [7:0] d, input logic [2:0] s,
                               input logic [3:0] c, output int lat);
    cmd_valid = 1'b1; cmd_data = d; cmd_sel = s; cmd_count = c;
    tick();
    cmd_valid = 1'b0;
    lat = 0;
    while (!result_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    vectors++;
    if ({Load, Select, Data_in} !== 12'h000) begin
      miscompares++; $display("FAIL reset_barrel_outs: got %h expected %h", {Load, Select, Data_in}, 12'h000);
    end
    vectors++;
    if ({result_valid, result_data} !== 9'h000) begin
      miscompares++; $display("FAIL reset_result: got %h expected %h", {result_valid, result_data}, 9'h000);
    end
    vectors++;
    if ({busy, cmd_ready} !== 2'b01) begin
      miscompares++; $display("FAIL reset_busy_ready: got %b expected %b", {busy, cmd_ready}, 2'b01);
    end
    Reset = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single();
    int lat, l0, s0, r0;
    l0 = n_load; s0 = n_sel; r0 = res_q.size();
    push_and_wait(8'h14, 3'd3, 4'd1, lat);
    // pop, LOAD, ROTATE, CAPTURE: strobe rises on the 4th edge after the push edge
    vectors++;
    if (lat !== 4) begin
      miscompares++; $display("FAIL single_latency: got %0d expected %0d", lat, 4);
    end
    vectors++;
    if (result_data !== 8'hA0) begin
      miscompares++; $display("FAIL single_result: got %h expected %h", result_data, 8'hA0);
    end
    vectors++;
    if ((n_load - l0) !== 1 || last_load !== 8'h14) begin
      miscompares++; $display("FAIL single_load: got %0d/%h expected 1/14", n_load - l0, last_load);
    end
    vectors++;
    if ((n_sel - s0) !== 1 || last_sel !== 3'd3) begin
      miscompares++; $display("FAIL single_select: got %0d/%0d expected 1/3", n_sel - s0, last_sel);
    end
    tick();
    vectors++;
    if ({result_valid, busy} !== 2'b00) begin
      miscompares++; $display("FAIL single_pulse_busy: got %b expected %b", {result_valid, busy}, 2'b00);
    end
    repeat (3) tick();
    vectors++;
    if ((res_q.size() - r0) !== 1 || result_data !== 8'hA0 || Data_in !== 8'h14) begin
      miscompares++; $display("FAIL single_hold: got %0d/%h/%h expected 1/a0/14", res_q.size() - r0, result_data, Data_in);
    end
  endtask

  task automatic test_count_zero();
    int lat, s0;
    s0 = n_sel;
    push_and_wait(8'h14, 3'd5, 4'd0, lat);
    vectors++;
    if (lat !== 3 || result_data !== 8'h14) begin
      miscompares++; $display("FAIL count_zero: got %0d/%h expected 3/14", lat, result_data);
    end
    vectors++;
    if ((n_sel - s0) !== 0) begin
      miscompares++; $display("FAIL count_zero_select: got %0d expected %0d", n_sel - s0, 0);
    end
    repeat (2) tick();
  endtask

  task automatic test_multi_rotate();
    int lat, s0;
    s0 = n_sel;
    push_and_wait(8'h81, 3'd1, 4'd3, lat);
    vectors++;
    if (lat !== 6 || result_data !== 8'h0C) begin
      miscompares++; $display("FAIL multi_rotate: got %0d/%h expected 6/0c", lat, result_data);
    end
    vectors++;
    if ((n_sel - s0) !== 3 || last_sel !== 3'd1) begin
      miscompares++; $display("FAIL multi_rotate_select: got %0d/%0d expected 3/1", n_sel - s0, last_sel);
    end
    repeat (2) tick();
  endtask

  task automatic test_fifo_full();
    logic [7:0] fd [0:5];
    logic [2:0] fs [0:5];
    logic [3:0] fc [0:5];
    logic [7:0] exp_r [0:4];
    int base, w;
    fd = '{8'h11, 8'hE1, 8'h96, 8'h5A, 8'h01, 8'h03};
    fs = '{3'd1, 3'd4, 3'd3, 3'd7, 3'd1, 3'd2};
    fc = '{4'd1, 4'd1, 4'd0, 4'd1, 4'd1, 4'd0};
    exp_r = '{8'h0F, 8'h22, 8'h1E, 8'h96, 8'h2D};
    base = res_q.size();
    cmd_valid = 1'b1; cmd_data = 8'h3C; cmd_sel = 3'd2; cmd_count = 4'd15;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1; cmd_data = fd[i]; cmd_sel = fs[i]; cmd_count = fc[i];
      vectors++;
      if (cmd_ready !== (i < 4)) begin
        miscompares++; $display("FAIL full_ready_%0d: got %b expected %b", i, cmd_ready, (i < 4));
      end
      tick();
    end
    cmd_valid = 1'b0;
    vectors++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL full_hold: got %b%b expected 01", cmd_ready, busy);
    end
    w = 0;
    while ((res_q.size() - base) < 5 && w < 300) begin
      tick();
      w++;
    end
    repeat (10) tick();
    vectors++;
    if ((res_q.size() - base) !== 5) begin
      miscompares++; $display("FAIL full_result_count: got %0d expected %0d", res_q.size() - base, 5);
    end
    for (int k = 0; k < 5; k++) begin
      if (base + k < res_q.size()) begin
        vectors++;
        if (res_q[base + k] !== exp_r[k]) begin
          miscompares++; $display("FAIL full_result_%0d: got %h expected %h", k, res_q[base + k], exp_r[k]);
        end
      end
    end
    vectors++;
    if ({busy, cmd_ready} !== 2'b01) begin
      miscompares++; $display("FAIL full_drain: got %b expected %b", {busy, cmd_ready}, 2'b01);
    end
  endtask

  task automatic test_max_count();
    int lat, s0;
    s0 = n_sel;
    push_and_wait(8'h01, 3'd1, 4'd15, lat);
    vectors++;
    if (lat !== 18 || result_data !== 8'h80) begin
      miscompares++; $display("FAIL max_count: got %0d/%h expected 18/80", lat, result_data);
    end
    vectors++;
    if ((n_sel - s0) !== 15) begin
      miscompares++; $display("FAIL max_count_select: got %0d expected %0d", n_sel - s0, 15);
    end
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    int base;
    base = res_q.size();
    cmd_valid = 1'b1; cmd_data = 8'h55; cmd_sel = 3'd1; cmd_count = 4'd15;
    tick();
    cmd_data = 8'h77; cmd_sel = 3'd2; cmd_count = 4'd3;
    tick();
    cmd_valid = 1'b0;
    repeat (4) tick();
    vectors++;
    if ({busy, Select} !== 4'b1001) begin
      miscompares++; $display("FAIL mid_rotating: got %b expected %b", {busy, Select}, 4'b1001);
    end
    #2 Reset = 1'b0;
    #1;
    vectors++;
    if ({Load, Select, Data_in, result_valid, result_data} !== 21'h0) begin
      miscompares++; $display("FAIL mid_async_outs: got %h expected %h", {Load, Select, Data_in, result_valid, result_data}, 21'h0);
    end
    vectors++;
    if ({busy, cmd_ready} !== 2'b01) begin
      miscompares++; $display("FAIL mid_async_busy_ready: got %b expected %b", {busy, cmd_ready}, 2'b01);
    end
    repeat (3) tick();
    Reset = 1'b1;
    repeat (40) tick();
    vectors++;
    if ((res_q.size() - base) !== 0) begin
      miscompares++; $display("FAIL mid_no_result: got %0d expected %0d", res_q.size() - base, 0);
    end
    vectors++;
    if ({busy, cmd_ready, Load} !== 3'b010) begin
      miscompares++; $display("FAIL mid_after_release: got %b expected %b", {busy, cmd_ready, Load}, 3'b010);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_count_zero();
    test_multi_rotate();
    test_fifo_full();
    test_max_count();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
